// File: rtl/pipe_mem_access_pkg.sv
// Shared types for the memory-access pipeline stage.
// FSM state encoding plus datapath and register-index widths.
package pipe_mem_access_pkg;

    localparam int DATA_W = 64;
    localparam int REG_W  = 3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        DONE     = 2'd2
    } state_t;

endpackage

// File: rtl/pipe_mem_access_wb.sv
// MEM/WB output register: loads a result or a bubble when load is high.
// A bubble clears only the write enable; index and data keep their value.
module pipe_mem_wb
    import pipe_mem_access_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              bubble,
    input  logic              wen,
    input  logic [REG_W-1:0]  idx,
    input  logic [DATA_W-1:0] data,
    output logic              wb_wen,
    output logic [REG_W-1:0]  wb_idx,
    output logic [DATA_W-1:0] wb_data
);

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_wen  <= 1'b0;
            wb_idx  <= '0;
            wb_data <= '0;
        end else if (load) begin
            if (bubble) begin
                wb_wen <= 1'b0;
            end else begin
                wb_wen  <= wen;
                wb_idx  <= idx;
                wb_data <= data;
            end
        end
    end

endmodule

// File: rtl/pipe_mem_access.sv
// Memory-access stage: req/ack data-memory port, upstream stall, MEM/WB reg.
// Optional ack timeout enabled by defining MEM_TIMEOUT_EN.
module pipe_mem_access
    import pipe_mem_access_pkg::*;
#(
    parameter int ADDR_W         = 8,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              WRegEn_in,
    input  logic              WMemEn_in,
    input  logic              RMemEn_in,
    input  logic [DATA_W-1:0] R1out_in,
    input  logic [DATA_W-1:0] R2out_in,
    input  logic [REG_W-1:0]  WReg1_in,
    output logic              stall_out,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              WRegEn_out,
    output logic [REG_W-1:0]  WReg1_out,
    output logic [DATA_W-1:0] WData_out,
    output logic              mem_err_out
);

    state_t state, next;

    logic              memop;
    logic              accept;
    logic              timeout;
    logic              cap_wen;
    logic [REG_W-1:0]  cap_idx;
    logic [DATA_W-1:0] hold_data;

    logic              wb_load;
    logic              wb_bubble;
    logic              wb_wen;
    logic [REG_W-1:0]  wb_idx;
    logic [DATA_W-1:0] wb_data;

    assign memop = WMemEn_in | RMemEn_in;

`ifdef MEM_TIMEOUT_EN
    localparam logic [3:0] TO_LAST = 4'(TIMEOUT_CYCLES - 1);

    logic [3:0] tcnt;

    assign timeout = (state == WAIT_ACK) && !dmem_ack && (tcnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            tcnt        <= 4'd0;
            mem_err_out <= 1'b0;
        end else begin
            mem_err_out <= timeout;
            if (accept || timeout) begin
                tcnt <= 4'd0;
            end else if (state == WAIT_ACK) begin
                tcnt <= dmem_ack ? 4'd0 : tcnt + 4'd1;
            end
        end
    end
`else
    logic unused_cfg;

    assign unused_cfg  = ^TIMEOUT_CYCLES;
    assign timeout     = 1'b0;
    assign mem_err_out = 1'b0;
`endif

    always_comb begin
        next      = state;
        stall_out = 1'b0;
        accept    = 1'b0;
        wb_load   = 1'b0;
        wb_bubble = 1'b0;
        wb_wen    = WRegEn_in;
        wb_idx    = WReg1_in;
        wb_data   = R1out_in;
        case (state)
            IDLE: begin
                if (en) begin
                    wb_load = 1'b1;
                    if (memop) begin
                        stall_out = 1'b1;
                        accept    = 1'b1;
                        wb_bubble = 1'b1;
                        next      = WAIT_ACK;
                    end
                end
            end
            WAIT_ACK: begin
                // A timed-out op retires as a bubble so upstream can move on.
                if (timeout) begin
                    wb_load   = 1'b1;
                    wb_bubble = 1'b1;
                    next      = IDLE;
                end else if (dmem_ack && en) begin
                    wb_load = 1'b1;
                    wb_wen  = cap_wen & ~dmem_we;
                    wb_idx  = cap_idx;
                    wb_data = dmem_rdata;
                    next    = IDLE;
                end else if (dmem_ack) begin
                    stall_out = 1'b1;
                    next      = DONE;
                end else begin
                    stall_out = 1'b1;
                    wb_load   = 1'b1;
                    wb_bubble = 1'b1;
                end
            end
            DONE: begin
                stall_out = ~en;
                if (en) begin
                    wb_load = 1'b1;
                    wb_wen  = cap_wen & ~dmem_we;
                    wb_idx  = cap_idx;
                    wb_data = hold_data;
                    next    = IDLE;
                end
            end
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            cap_wen    <= 1'b0;
            cap_idx    <= '0;
            hold_data  <= '0;
        end else begin
            state <= next;
            if (accept) begin
                dmem_req   <= 1'b1;
                dmem_we    <= WMemEn_in;
                dmem_addr  <= R1out_in[ADDR_W-1:0];
                dmem_wdata <= R2out_in;
                cap_wen    <= WRegEn_in;
                cap_idx    <= WReg1_in;
            end
            if (state == WAIT_ACK && (dmem_ack || timeout)) begin
                dmem_req <= 1'b0;
            end
            if (state == WAIT_ACK && dmem_ack && !en && !timeout) begin
                hold_data <= dmem_rdata;
            end
        end
    end

    pipe_mem_wb u_wb (
        .clk     (clk),
        .reset   (reset),
        .load    (wb_load),
        .bubble  (wb_bubble),
        .wen     (wb_wen),
        .idx     (wb_idx),
        .data    (wb_data),
        .wb_wen  (WRegEn_out),
        .wb_idx  (WReg1_out),
        .wb_data (WData_out)
    );

endmodule

// File: tb/tb_pipe_mem_access.sv
// Scoreboard bench for pipe_mem_access: stimulus queues expected writebacks,
// a negedge monitor pops them whenever a fresh WRegEn_out appears.
module tb_pipe_mem_access;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        WRegEn_in;
    logic        WMemEn_in;
    logic        RMemEn_in;
    logic [63:0] R1out_in;
    logic [63:0] R2out_in;
    logic [2:0]  WReg1_in;
    logic        stall_out;
    logic        dmem_req;
    logic        dmem_we;
    logic [7:0]  dmem_addr;
    logic [63:0] dmem_wdata;
    logic [63:0] dmem_rdata;
    logic        dmem_ack;
    logic        WRegEn_out;
    logic [2:0]  WReg1_out;
    logic [63:0] WData_out;
    logic        mem_err_out;

    typedef struct {
        logic [2:0]  idx;
        logic [63:0] data;
    } wb_t;

    wb_t exp_q[$];
    int  n_vec = 0;
    int  n_bad = 0;
    logic en_q = 1'b0;

    pipe_mem_access #(.ADDR_W(8), .TIMEOUT_CYCLES(15)) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .WRegEn_in   (WRegEn_in),
        .WMemEn_in   (WMemEn_in),
        .RMemEn_in   (RMemEn_in),
        .R1out_in    (R1out_in),
        .R2out_in    (R2out_in),
        .WReg1_in    (WReg1_in),
        .stall_out   (stall_out),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_rdata  (dmem_rdata),
        .dmem_ack    (dmem_ack),
        .WRegEn_out  (WRegEn_out),
        .WReg1_out   (WReg1_out),
        .WData_out   (WData_out),
        .mem_err_out (mem_err_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) en_q <= en && !reset;

    // A writeback is fresh only if the output register was enabled last edge.
    always @(negedge clk) begin
        if (en_q && WRegEn_out) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL wb_unexpected: got reg=%0d data=%h, expected none",
                         WReg1_out, WData_out);
            end else begin
                wb_t e;
                e = exp_q.pop_front();
                if (WReg1_out !== e.idx || WData_out !== e.data) begin
                    n_bad++;
                    $display("FAIL wb_result: got reg=%0d data=%h, expected reg=%0d data=%h",
                             WReg1_out, WData_out, e.idx, e.data);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] idx, input logic [63:0] data);
        wb_t e;
        e.idx  = idx;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic nop();
        en        = 1'b1;
        WRegEn_in = 1'b0;
        WMemEn_in = 1'b0;
        RMemEn_in = 1'b0;
        R1out_in  = 64'h0;
        R2out_in  = 64'h0;
        WReg1_in  = 3'd0;
        dmem_ack  = 1'b0;
    endtask

    task automatic op(input logic w, input logic r, input logic wen,
                      input logic [63:0] a, input logic [63:0] d, input logic [2:0] rd);
        en        = 1'b1;
        WMemEn_in = w;
        RMemEn_in = r;
        WRegEn_in = wen;
        R1out_in  = a;
        R2out_in  = d;
        WReg1_in  = rd;
    endtask

    initial begin
        reset      = 1'b1;
        dmem_rdata = 64'h0;
        nop();
        en = 1'b0;
        tick();
        tick();
        chk("rst_req", {63'd0, dmem_req}, 64'd0);
        chk("rst_wen", {63'd0, WRegEn_out}, 64'd0);
        chk("rst_data", WData_out, 64'd0);
        chk("rst_addr", {56'd0, dmem_addr}, 64'd0);
        chk("rst_err", {63'd0, mem_err_out}, 64'd0);
        reset = 1'b0;

        // ALU pass-through, then a second op back to back
        op(1'b0, 1'b0, 1'b1, 64'h1234, 64'h0, 3'd3);
        push(3'd3, 64'h1234);
        #1 chk("alu_stall", {63'd0, stall_out}, 64'd0);
        tick();
        op(1'b0, 1'b0, 1'b1, 64'hAAAA_0000_5555, 64'h0, 3'd7);
        push(3'd7, 64'hAAAA_0000_5555);
        #1 chk("alu2_stall", {63'd0, stall_out}, 64'd0);
        tick();
        // en low: nothing accepted even with a valid-looking op present
        op(1'b0, 1'b0, 1'b1, 64'hBAD, 64'h0, 3'd1);
        en = 1'b0;
        #1 chk("en0_stall", {63'd0, stall_out}, 64'd0);
        tick();
        chk("en0_hold", WData_out, 64'hAAAA_0000_5555);
        nop();
        tick();

        // load, ack on third wait cycle
        op(1'b0, 1'b1, 1'b1, 64'hFF40, 64'h0, 3'd5);
        push(3'd5, 64'hDEAD_BEEF);
        #1 chk("ld_stall0", {63'd0, stall_out}, 64'd1);
        tick();
        chk("ld_req1", {63'd0, dmem_req}, 64'd1);
        chk("ld_we", {63'd0, dmem_we}, 64'd0);
        chk("ld_addr", {56'd0, dmem_addr}, 64'h40);
        chk("ld_stall1", {63'd0, stall_out}, 64'd1);
        chk("ld_bub1", {63'd0, WRegEn_out}, 64'd0);
        tick();
        chk("ld_req2", {63'd0, dmem_req}, 64'd1);
        chk("ld_stall2", {63'd0, stall_out}, 64'd1);
        tick();
        chk("ld_req3", {63'd0, dmem_req}, 64'd1);
        dmem_ack   = 1'b1;
        dmem_rdata = 64'hDEAD_BEEF;
        #1 chk("ld_stall_ack", {63'd0, stall_out}, 64'd0);
        tick();
        nop();
        chk("ld_req_off", {63'd0, dmem_req}, 64'd0);
        chk("ld_wen", {63'd0, WRegEn_out}, 64'd1);
        tick();

        // store with write-enable set must not write back; both enables -> store
        op(1'b1, 1'b1, 1'b1, 64'h10, 64'hA5, 3'd2);
        tick();
        chk("st_we", {63'd0, dmem_we}, 64'd1);
        chk("st_wdata", dmem_wdata, 64'hA5);
        chk("st_addr", {56'd0, dmem_addr}, 64'h10);
        dmem_ack   = 1'b1;
        dmem_rdata = 64'h999;
        #1 chk("st_stall_ack", {63'd0, stall_out}, 64'd0);
        tick();
        nop();
        chk("st_wen", {63'd0, WRegEn_out}, 64'd0);
        tick();

        // load with en dropped on the ack cycle
        op(1'b0, 1'b1, 1'b1, 64'h20, 64'h0, 3'd6);
        push(3'd6, 64'h77);
        tick();
        dmem_ack   = 1'b1;
        dmem_rdata = 64'h77;
        en         = 1'b0;
        #1 chk("done_stall_ack", {63'd0, stall_out}, 64'd1);
        tick();
        dmem_ack   = 1'b0;
        dmem_rdata = 64'h0;
        chk("done_stall1", {63'd0, stall_out}, 64'd1);
        chk("done_req", {63'd0, dmem_req}, 64'd0);
        // stray ack while parked in DONE
        dmem_ack   = 1'b1;
        dmem_rdata = 64'hBAD;
        tick();
        dmem_ack = 1'b0;
        chk("done_stall2", {63'd0, stall_out}, 64'd1);
        en = 1'b1;
        #1 chk("done_release", {63'd0, stall_out}, 64'd0);
        tick();
        nop();
        chk("done_wen", {63'd0, WRegEn_out}, 64'd1);
        tick();

        // back-to-back loads, acked immediately
        op(1'b0, 1'b1, 1'b1, 64'h30, 64'h0, 3'd1);
        push(3'd1, 64'h1111);
        tick();
        dmem_ack   = 1'b1;
        dmem_rdata = 64'h1111;
        tick();
        dmem_ack = 1'b0;
        op(1'b0, 1'b1, 1'b1, 64'h31, 64'h0, 3'd4);
        push(3'd4, 64'h2222);
        tick();
        chk("b2b_addr", {56'd0, dmem_addr}, 64'h31);
        dmem_ack   = 1'b1;
        dmem_rdata = 64'h2222;
        tick();
        nop();
        tick();

        // reset in WAIT_ACK, late ack ignored
        op(1'b0, 1'b1, 1'b1, 64'h55, 64'h0, 3'd2);
        tick();
        chk("rw_req_on", {63'd0, dmem_req}, 64'd1);
        nop();
        en    = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rw_req_off", {63'd0, dmem_req}, 64'd0);
        chk("rw_wen", {63'd0, WRegEn_out}, 64'd0);
        chk("rw_reg", {61'd0, WReg1_out}, 64'd0);
        chk("rw_data", WData_out, 64'd0);
        nop();
        tick();
        dmem_ack   = 1'b1;
        dmem_rdata = 64'h123;
        #1 chk("rw_late_stall", {63'd0, stall_out}, 64'd0);
        tick();
        dmem_ack = 1'b0;
        chk("rw_late_req", {63'd0, dmem_req}, 64'd0);
        chk("rw_late_wen", {63'd0, WRegEn_out}, 64'd0);
        tick();

`ifdef MEM_TIMEOUT_EN
        op(1'b0, 1'b1, 1'b1, 64'h66, 64'h0, 3'd3);
        tick();
        for (int i = 1; i <= 15; i++) begin
            chk("to_req", {63'd0, dmem_req}, 64'd1);
            chk("to_err_low", {63'd0, mem_err_out}, 64'd0);
            tick();
        end
        nop();
        chk("to_req_off", {63'd0, dmem_req}, 64'd0);
        chk("to_err", {63'd0, mem_err_out}, 64'd1);
        chk("to_wen", {63'd0, WRegEn_out}, 64'd0);
        tick();
        chk("to_err_pulse", {63'd0, mem_err_out}, 64'd0);
        chk("to_idle_req", {63'd0, dmem_req}, 64'd0);
        tick();
`else
        chk("no_err", {63'd0, mem_err_out}, 64'd0);
`endif

        tick();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL wb_missing: got %0d pending, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
